scan_sel_gen: RTL and testbench
===============================

Name: scan_sel_gen

Overview:
- Upstream driver for decoder_3_8: generates its enable (E) and 3-bit select (In) so the decoder strobes its 8 outputs in sequence.
- Programmable dwell per select value; up or down direction; continuous or single-sweep operation; start/stop control.
- Sits between control logic and decoder_3_8. E and In connect directly to the decoder's E and In ports.

Parameters:
- DWELL_W, 8, width of the dwell count; each select value is held dwell+1 cycles.
- SEL_W, 3, select width; fixed at 3 to match decoder_3_8. Wrap points are 0 and 7.

Ports:
- clka  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request to begin scanning; sampled only in IDLE.
- stop  in  1  abort scanning; sampled only in RUN.
- mode  in  2  00 up-continuous, 01 down-continuous, 10 up-single, 11 down-single.
- dwell  in  DWELL_W  hold count; each select value lasts dwell+1 cycles.
- E  out  1  decoder enable, registered.
- In  out  3  decoder select, registered.
- busy  out  1  high while in RUN.
- sweep_done  out  1  one-cycle pulse at the end of a single sweep.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-run):
  - state=IDLE; E=0, In=0, busy=0, sweep_done=0.
  - Dwell counter=0; shadow registers mode_q=0 and dwell_q=0.
- States: IDLE, RUN.
- IDLE:
  - E=0 and busy=0.
  - In holds its last value. After reset that value is 0.
  - If start=1 at an edge:
    - capture mode->mode_q and dwell->dwell_q;
    - In <= 0 for up modes, 7 for down modes;
    - E <= 1, busy <= 1, counter <= 0; go to RUN.
  - Latency: E and the first In are valid in the cycle after the start edge.
- RUN:
  - Counter increments each cycle.
  - When counter==dwell_q (dwell expiry), the counter resets to 0 and In steps by +1 (up) or -1 (down), wrapping modulo 8 (7->0 up, 0->7 down).
  - dwell_q=0: In changes every cycle.
  - Continuous modes run until stop.
  - Single modes: dwell expiry at the last value (7 for up, 0 for down) ends the sweep:
    - go to IDLE; E <= 0, busy <= 0;
    - sweep_done <= 1 for exactly one cycle;
    - In holds the last value (7 or 0).
  - Single sweep total: E is high for exactly 8*(dwell_q+1) cycles.
- stop=1 in RUN:
  - next edge goes to IDLE; E <= 0, busy <= 0;
  - no sweep_done pulse; In holds its current value.
- Simultaneous stop and final-value expiry: stop wins; no sweep_done.
- start while in RUN is ignored.
- start and stop together in IDLE: start is honoured; stop is ignored in IDLE.
- Changes to mode or dwell during RUN have no effect; shadow values are used until the next start.
- Back-to-back: start asserted in the cycle where sweep_done=1 starts a new sweep, because the block is already in IDLE.
- E and In update on the same edge, so the decoder never sees an enable/select glitch between registers.

Decomposition:
- Package scan_pkg:
  - typedef enum for mode: SCAN_UP_CONT, SCAN_DN_CONT, SCAN_UP_ONE, SCAN_DN_ONE;
  - typedef enum for state: ST_IDLE, ST_RUN;
  - constants SEL_MAX=3'd7 and SEL_MIN=3'd0.
- One sub-module, dwell_timer:
  - holds the counter and compare;
  - inputs: clka, rst, clr, en, dwell_q;
  - output: expire pulse.
- Top level holds the FSM, shadow registers and select stepping.

Test Plan:
- Reset mid-RUN: assert rst while In=3 -> E=0, In=0, busy=0 immediately, before the next clka edge.
- mode=10, dwell=0, start pulse -> In steps 0,1,...,7 over 8 cycles with E=1; then E=0, sweep_done high for 1 cycle, In=7, busy=0.
- mode=11, dwell=2 -> In steps 7,6,...,0, each value held 3 cycles; E high for 24 cycles; one sweep_done pulse.
- mode=00, dwell=1, run 20 cycles -> sequence 0,0,1,1,...,7,7,0,0,1,1 (wrap 7->0); assert stop -> E=0 next edge, no sweep_done.
- mode=10, dwell=0, stop asserted in the cycle In=7 expires -> IDLE, no sweep_done. Separately, change dwell mid-run -> step timing unchanged.
- Instantiate with decoder_3_8: mode=00, dwell=0 -> decoder Out cycles 8'h01,8'h02,...,8'h80, then 8'h01 again. Before start, Out=8'h00 because E=0.

Source files
------------

// File: rtl/scan_pkg.sv
// scan_pkg: shared types and constants for scan_sel_gen.
//   scan_mode_t  : 2-bit operating mode (bit0 = down, bit1 = single sweep)
//   scan_state_t : controller state
//   SEL_MAX/MIN  : select wrap points seen by decoder_3_8
package scan_pkg;

  typedef enum logic [1:0] {
    SCAN_UP_CONT = 2'b00,
    SCAN_DN_CONT = 2'b01,
    SCAN_UP_ONE  = 2'b10,
    SCAN_DN_ONE  = 2'b11
  } scan_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_t;

  localparam logic [2:0] SEL_MAX = 3'd7;
  localparam logic [2:0] SEL_MIN = 3'd0;

  function automatic logic mode_is_down(scan_mode_t m);
    return (m == SCAN_DN_CONT) || (m == SCAN_DN_ONE);
  endfunction

  function automatic logic mode_is_single(scan_mode_t m);
    return (m == SCAN_UP_ONE) || (m == SCAN_DN_ONE);
  endfunction

endpackage

// File: rtl/scan_sel_gen_dwell_timer.sv
// dwell_timer: counts cycles spent on the current select value.
//   clka    : clock, rising edge
//   rst     : asynchronous active-high reset
//   clr     : hold counter at zero (used while idle)
//   en      : count enable (used while running)
//   dwell_q : captured dwell; each value lasts dwell_q+1 cycles
//   expire  : high in the last cycle of a dwell period
module dwell_timer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clka,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell_q,
  output logic               expire
);

  logic [DWELL_W-1:0] count;

  assign expire = en && !clr && (count == dwell_q);

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= expire ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/scan_sel_gen.sv
// scan_sel_gen: drives E/In of decoder_3_8 so its outputs strobe in sequence.
//   clka       : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : begin scanning (honoured only when idle)
//   stop       : abort scanning (honoured only when running)
//   mode       : 00 up-cont, 01 down-cont, 10 up-single, 11 down-single
//   dwell      : each select value is held dwell+1 cycles
//   E, In      : registered decoder enable and select
//   busy       : high while running
//   sweep_done : one-cycle pulse after a single sweep completes
module scan_sel_gen
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned SEL_W   = 3
) (
  input  logic               clka,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               E,
  output logic [SEL_W-1:0]   In,
  output logic               busy,
  output logic               sweep_done
);

  scan_state_t        state, state_n;
  scan_mode_t         mode_q, mode_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic [SEL_W-1:0]   sel_n;
  logic [SEL_W-1:0]   last_sel;
  logic               done_n;
  logic               timer_clr;
  logic               timer_en;
  logic               expire;

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clka    (clka),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .dwell_q (dwell_q),
    .expire  (expire)
  );

  assign last_sel = mode_is_down(mode_q) ? SEL_MIN : SEL_MAX;

  always_comb begin
    state_n   = state;
    mode_n    = mode_q;
    dwell_n   = dwell_q;
    sel_n     = In;
    done_n    = 1'b0;
    timer_clr = 1'b1;
    timer_en  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          mode_n  = scan_mode_t'(mode);
          dwell_n = dwell;
          sel_n   = mode_is_down(scan_mode_t'(mode)) ? SEL_MAX : SEL_MIN;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        timer_clr = 1'b0;
        timer_en  = 1'b1;
        // stop takes priority over a coincident end-of-sweep expiry
        if (stop) begin
          state_n = ST_IDLE;
        end else if (expire) begin
          if (mode_is_single(mode_q) && (In == last_sel)) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            sel_n = mode_is_down(mode_q) ? In - 1'b1 : In + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // E, busy and In are all loaded from next-state values on one edge,
  // so the decoder never sees enable and select disagree.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      E          <= 1'b0;
      In         <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      mode_q     <= SCAN_UP_CONT;
      dwell_q    <= '0;
    end else begin
      state      <= state_n;
      E          <= (state_n == ST_RUN);
      busy       <= (state_n == ST_RUN);
      In         <= sel_n;
      sweep_done <= done_n;
      mode_q     <= mode_n;
      dwell_q    <= dwell_n;
    end
  end

endmodule

// File: tb/tb_scan_sel_gen.sv
module tb_scan_sel_gen;

  logic       clka = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] dwell = 8'd0;
  logic       E, busy, sweep_done;
  logic [2:0] In;
  logic [5:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  scan_sel_gen #(
    .DWELL_W (8),
    .SEL_W   (3)
  ) dut (
    .clka       (clka),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .dwell      (dwell),
    .E          (E),
    .In         (In),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clka = ~clka;

  assign obs = {E, busy, sweep_done, In};

  // Select value k cycles after the start edge: one step per dwell+1 cycles.
  function automatic logic [2:0] exp_sel(logic [1:0] m, int d, int k);
    int steps;
    int v;
    steps = k / (d + 1);
    v = m[0] ? (7 - steps) : steps;
    return 3'(v & 7);
  endfunction

  // Behaviour of decoder_3_8 driven by E/In.
  function automatic logic [7:0] dec(logic e, logic [2:0] s);
    return e ? (8'd1 << s) : 8'd0;
  endfunction

  task automatic do_start(logic [1:0] m, int d);
    @(negedge clka);
    mode  = m;
    dwell = 8'(d);
    start = 1'b1;
    @(negedge clka);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (obs !== 6'b000_000) begin
      n_fail++; $display("FAIL reset_async: got %b expected %b", obs, 6'b0);
    end
    @(negedge clka);
    rst = 1'b0;
    repeat (2) @(negedge clka);
    n_checks++;
    if (obs !== 6'b000_000) begin
      n_fail++; $display("FAIL reset_idle: got %b expected %b", obs, 6'b0);
    end
  endtask

  task automatic test_single_up;
    do_start(2'b10, 0);
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (obs !== {3'b110, exp_sel(2'b10, 0, k)}) begin
        n_fail++; $display("FAIL single_up k=%0d: got %b expected %b", k, obs, {3'b110, exp_sel(2'b10, 0, k)});
      end
      @(negedge clka);
    end
    n_checks++;
    if (obs !== 6'b001_111) begin
      n_fail++; $display("FAIL single_up_end: got %b expected %b", obs, 6'b001_111);
    end
    @(negedge clka);
    n_checks++;
    if (obs !== 6'b000_111) begin
      n_fail++; $display("FAIL single_up_after: got %b expected %b", obs, 6'b000_111);
    end
  endtask

  task automatic test_single_down;
    int e_cycles = 0;
    int pulses = 0;
    do_start(2'b11, 2);
    for (int k = 0; k < 24; k++) begin
      n_checks++;
      if (obs !== {3'b110, exp_sel(2'b11, 2, k)}) begin
        n_fail++; $display("FAIL single_down k=%0d: got %b expected %b", k, obs, {3'b110, exp_sel(2'b11, 2, k)});
      end
      @(negedge clka);
    end
    for (int k = 0; k < 30; k++) begin
      if (k == 0) begin
        n_checks++;
        if (obs !== 6'b001_000) begin
          n_fail++; $display("FAIL single_down_end: got %b expected %b", obs, 6'b001_000);
        end
      end
      e_cycles += int'(E);
      pulses   += int'(sweep_done);
      @(negedge clka);
    end
    e_cycles += 24;
    n_checks++;
    if (e_cycles !== 24 || pulses !== 1) begin
      n_fail++; $display("FAIL single_down_counts: got E=%0d pulses=%0d expected E=24 pulses=1", e_cycles, pulses);
    end
  endtask

  task automatic test_continuous;
    do_start(2'b00, 1);
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (obs !== {3'b110, exp_sel(2'b00, 1, k)}) begin
        n_fail++; $display("FAIL cont k=%0d: got %b expected %b", k, obs, {3'b110, exp_sel(2'b00, 1, k)});
      end
      if (k == 19) stop = 1'b1;
      @(negedge clka);
    end
    stop = 1'b0;
    n_checks++;
    if (obs !== {3'b000, exp_sel(2'b00, 1, 19)}) begin
      n_fail++; $display("FAIL cont_stop: got %b expected %b", obs, {3'b000, exp_sel(2'b00, 1, 19)});
    end
    @(negedge clka);
    n_checks++;
    if (obs !== {3'b000, exp_sel(2'b00, 1, 19)}) begin
      n_fail++; $display("FAIL cont_stop_hold: got %b expected %b", obs, {3'b000, exp_sel(2'b00, 1, 19)});
    end
  endtask

  task automatic test_stop_final;
    do_start(2'b10, 0);
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (obs !== {3'b110, exp_sel(2'b10, 0, k)}) begin
        n_fail++; $display("FAIL stop_final k=%0d: got %b expected %b", k, obs, {3'b110, exp_sel(2'b10, 0, k)});
      end
      if (k == 7) stop = 1'b1;
      @(negedge clka);
    end
    stop = 1'b0;
    n_checks++;
    if (obs !== 6'b000_111) begin
      n_fail++; $display("FAIL stop_final_end: got %b expected %b", obs, 6'b000_111);
    end
    @(negedge clka);
    n_checks++;
    if (obs !== 6'b000_111) begin
      n_fail++; $display("FAIL stop_final_nopulse: got %b expected %b", obs, 6'b000_111);
    end
  endtask

  task automatic test_shadow;
    do_start(2'b10, 1);
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (obs !== {3'b110, exp_sel(2'b10, 1, k)}) begin
        n_fail++; $display("FAIL shadow k=%0d: got %b expected %b", k, obs, {3'b110, exp_sel(2'b10, 1, k)});
      end
      dwell = 8'($urandom_range(0, 255));
      mode  = 2'($urandom_range(0, 3));
      start = 1'($urandom_range(0, 1));
      @(negedge clka);
    end
    start = 1'b0;
    n_checks++;
    if (obs !== 6'b001_111) begin
      n_fail++; $display("FAIL shadow_end: got %b expected %b", obs, 6'b001_111);
    end
  endtask

  task automatic test_back_to_back;
    do_start(2'b11, 0);
    repeat (8) @(negedge clka);
    n_checks++;
    if (obs !== 6'b001_000) begin
      n_fail++; $display("FAIL b2b_first_end: got %b expected %b", obs, 6'b001_000);
    end
    mode  = 2'b10;
    dwell = 8'd0;
    start = 1'b1;
    @(negedge clka);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (obs !== {3'b110, exp_sel(2'b10, 0, k)}) begin
        n_fail++; $display("FAIL b2b k=%0d: got %b expected %b", k, obs, {3'b110, exp_sel(2'b10, 0, k)});
      end
      @(negedge clka);
    end
    n_checks++;
    if (obs !== 6'b001_111) begin
      n_fail++; $display("FAIL b2b_end: got %b expected %b", obs, 6'b001_111);
    end
  endtask

  task automatic test_start_stop_idle;
    @(negedge clka);
    mode  = 2'b00;
    dwell = 8'd0;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clka);
    start = 1'b0;
    stop  = 1'b0;
    n_checks++;
    if (obs !== 6'b110_000) begin
      n_fail++; $display("FAIL start_stop_idle: got %b expected %b", obs, 6'b110_000);
    end
    stop = 1'b1;
    @(negedge clka);
    stop = 1'b0;
    n_checks++;
    if (obs !== 6'b000_000) begin
      n_fail++; $display("FAIL start_stop_halt: got %b expected %b", obs, 6'b000_000);
    end
  endtask

  task automatic test_decoder;
    n_checks++;
    if (dec(E, In) !== 8'h00) begin
      n_fail++; $display("FAIL decoder_idle: got %h expected %h", dec(E, In), 8'h00);
    end
    do_start(2'b00, 0);
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (dec(E, In) !== (8'd1 << (k % 8))) begin
        n_fail++; $display("FAIL decoder k=%0d: got %h expected %h", k, dec(E, In), 8'd1 << (k % 8));
      end
      if (k == 9) stop = 1'b1;
      @(negedge clka);
    end
    stop = 1'b0;
    n_checks++;
    if (dec(E, In) !== 8'h00) begin
      n_fail++; $display("FAIL decoder_stopped: got %h expected %h", dec(E, In), 8'h00);
    end
  endtask

  task automatic test_reset_mid_run;
    do_start(2'b00, 0);
    repeat (3) @(negedge clka);
    n_checks++;
    if (obs !== 6'b110_011) begin
      n_fail++; $display("FAIL rst_mid_pre: got %b expected %b", obs, 6'b110_011);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 6'b000_000) begin
      n_fail++; $display("FAIL rst_mid_async: got %b expected %b", obs, 6'b000_000);
    end
    @(negedge clka);
    rst = 1'b0;
    @(negedge clka);
    n_checks++;
    if (obs !== 6'b000_000) begin
      n_fail++; $display("FAIL rst_mid_after: got %b expected %b", obs, 6'b000_000);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      logic [1:0] m;
      int d, len, stop_k, last_k;
      bit stopped;
      m       = 2'($urandom_range(0, 3));
      d       = int'($urandom_range(0, 3));
      len     = 8 * (d + 1);
      stop_k  = m[1] ? int'($urandom_range(0, len + 4)) : int'($urandom_range(0, 39));
      stopped = 1'b0;
      last_k  = 0;
      do_start(m, d);
      for (int k = 0; k < 64; k++) begin
        last_k = k;
        n_checks++;
        if (obs !== {3'b110, exp_sel(m, d, k)}) begin
          n_fail++; $display("FAIL random it=%0d k=%0d: got %b expected %b", it, k, obs, {3'b110, exp_sel(m, d, k)});
        end
        mode  = 2'($urandom_range(0, 3));
        dwell = 8'($urandom_range(0, 255));
        start = 1'($urandom_range(0, 1));
        if (k == stop_k) begin
          stop    = 1'b1;
          stopped = 1'b1;
        end
        @(negedge clka);
        stop  = 1'b0;
        start = 1'b0;
        if (stopped || (m[1] && k == len - 1)) break;
      end
      n_checks++;
      if (obs !== (stopped ? {3'b000, exp_sel(m, d, last_k)} : {3'b001, exp_sel(m, d, len - 1)})) begin
        n_fail++; $display("FAIL random_end it=%0d: got %b expected %b", it, obs,
                           stopped ? {3'b000, exp_sel(m, d, last_k)} : {3'b001, exp_sel(m, d, len - 1)});
      end
      @(negedge clka);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_up();
    test_single_down();
    test_continuous();
    test_stop_final();
    test_shadow();
    test_back_to_back();
    test_start_stop_idle();
    test_decoder();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
